// File: rtl/vga_digit_writer.sv
// rtl/vga_digit_writer.sv - arbitrated binary-to-decimal glyph writer for the VGA display slot file
// Round-robin picks a requester, double-dabble converts its value, then writes one glyph per slot MSD first.
module vga_digit_writer #(
  parameter int NDIGITS       = 10,
  parameter int NSLOTS        = 40,
  parameter int BLANK_CODE    = 11,
  parameter int LEADING_BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_value,
  input  logic [7:0]  req0_base,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_value,
  input  logic [7:0]  req1_base,
  output logic        av_chipselect,
  output logic        av_write,
  output logic [7:0]  av_address,
  output logic [31:0] av_writedata,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        done_id
);

  localparam int BW = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WRITE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_ptr;
  logic            r_id;
  logic [31:0]     r_value;
  logic [7:0]      r_base;
  logic [BW-1:0]   r_bcd;
  logic [4:0]      r_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_seen;
  logic            r_done;
  logic            r_done_id;

  logic            w_any;
  logic            w_grant;
  logic            w_hs;
  logic [BW-1:0]   w_adj;
  logic [3:0]      w_digit;
  logic [8:0]      w_slot;
  logic            w_in_range;
  logic            w_blank;
  logic [3:0]      w_code;
  logic            w_writing;
  logic            w_advance;
  logic            w_last;

  // Pointer side wins when valid; otherwise whichever requester is valid.
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (r_ptr ? req1_valid : req0_valid) ? r_ptr : ~r_ptr;
  assign w_hs    = (r_state == S_IDLE) && w_any;

  assign req0_ready = !reset && w_hs && (w_grant == 1'b0);
  assign req1_ready = !reset && w_hs && (w_grant == 1'b1);

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NDIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_digit = 4'd0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (IW'(NDIGITS - 1 - d) == r_idx) w_digit = r_bcd[4*d +: 4];
    end
  end

  assign w_slot     = {1'b0, r_base} + {{(9-IW){1'b0}}, r_idx};
  assign w_in_range = w_slot < 9'(NSLOTS);
  assign w_last     = (r_idx == IDX_LAST);
  // r_seen remembers a nonzero digit already emitted, so only leading zeros blank.
  assign w_blank    = (LEADING_BLANK != 0) && !r_seen && (w_digit == 4'd0) && !w_last;
  assign w_code     = w_blank ? 4'(BLANK_CODE) : w_digit;
  assign w_writing  = (r_state == S_WRITE) && w_in_range;
  assign w_advance  = (r_state == S_WRITE) && (!w_in_range || !av_waitrequest);

  assign av_chipselect = w_writing;
  assign av_write      = w_writing;
  assign av_address    = w_writing ? w_slot[7:0] : 8'd0;
  assign av_writedata  = w_writing ? {28'd0, w_code} : 32'd0;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign done_id       = r_done_id;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_hs) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == 5'd31) w_next = S_WRITE;
      S_WRITE:   if (w_advance && w_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_value   <= 32'd0;
      r_base    <= 8'd0;
      r_bcd     <= '0;
      r_cnt     <= 5'd0;
      r_idx     <= '0;
      r_seen    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_value <= w_grant ? req1_value : req0_value;
            r_base  <= w_grant ? req1_base : req0_base;
            r_id    <= w_grant;
            r_ptr   <= ~w_grant;
            r_bcd   <= '0;
            r_cnt   <= 5'd0;
            r_seen  <= 1'b0;
          end
        end
        S_CONVERT: begin
          r_bcd   <= {w_adj[BW-2:0], r_value[31]};
          r_value <= {r_value[30:0], 1'b0};
          r_cnt   <= r_cnt + 5'd1;
          r_idx   <= '0;
        end
        S_WRITE: begin
          if (w_advance) begin
            r_idx  <= r_idx + IDX_ONE;
            r_seen <= r_seen | (w_digit != 4'd0);
            if (w_last) begin
              r_done    <= 1'b1;
              r_done_id <= r_id;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
